// File: rtl/divu_seq.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// q/r hold the last completed result; busy covers exactly WIDTH cycles per operation.
module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy
);

    // Handshake: start is a level request, accepted on a rising edge only while
    // busy=0; operands are sampled on that edge, and busy falls on the edge q/r update.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // The shifted remainder is always below twice the divisor, so bit WIDTH of
    // the trial difference is a sufficient sign bit.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        rem_next = shifted;
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next    = trial;
            quo_next[0] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        dvs   <= divisor;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        q     <= quo_next;
                        r     <= rem_next[WIDTH-1:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Randomized and directed bench for divu_seq, scored against plain / and % arithmetic.
module tb_divu_seq;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    divu_seq #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .dividend(dividend),
        .divisor (divisor),
        .start   (start),
        .q       (q),
        .r       (r),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned divide, with divide-by-zero giving all ones and the dividend.
    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) begin
            exp_q.push_back({W{1'b1}});
            exp_q.push_back(a);
        end else begin
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where busy has fallen.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit disturb);
        int n;
        bit stable;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        model_push(a, b);
        @(negedge clock);
        if (!hold) start = 1'b0;
        n = 0;
        stable = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (q !== last_q || r !== last_r) stable = 1'b0;
            if (disturb && n == 5) begin
                dividend = $urandom;
                divisor  = $urandom;
                start    = 1'b1;
            end
            if (disturb && n == 7 && !hold) start = 1'b0;
            @(negedge clock);
        end
        check_eq({tag, "_busy_cycles"}, W'(n), W'(32));
        check_eq({tag, "_qr_stable"}, W'(stable), W'(1));
        if (exp_q.size() >= 2) begin
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            check_eq({tag, "_q"}, q, eq);
            check_eq({tag, "_r"}, r, er);
            last_q = eq;
            last_r = er;
        end else begin
            check_eq({tag, "_scoreboard_empty"}, W'(exp_q.size()), W'(2));
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("reset_busy", W'(busy), W'(0));
        @(negedge clock);
        reset = 1'b0;
        last_q = '0;
        last_r = '0;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        #1;
        check_eq("por_q", q, '0);
        check_eq("por_r", r, '0);
        check_eq("por_busy", W'(busy), W'(0));
        @(negedge clock);
        reset = 1'b0;

        run_op("t1", 32'h0000_7FFF, 32'h0000_0010, 1'b0, 1'b0);
        reset_pulse();
        run_op("t2", 32'hFFFF_FFF8, 32'h0000_0003, 1'b0, 1'b0);
        reset_pulse();
        run_op("t3", 32'hFFFF_FFF8, 32'h0000_0002, 1'b0, 1'b0);
        run_op("t4_div0", 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        run_op("max_by_one", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("small_by_big", 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(1, 255));
                1: b = $urandom >> $urandom_range(0, 31);
                2: b = '0;
                default: b = $urandom;
            endcase
            run_op("rand", a, b, 1'b0, 1'b0);
        end

        // Abort mid-operation: outputs clear without a clock edge.
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0007;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_q", q, '0);
        check_eq("abort_r", r, '0);
        check_eq("abort_busy", W'(busy), W'(0));
        @(negedge clock);
        reset = 1'b0;
        last_q = '0;
        last_r = '0;
        run_op("after_abort", 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0);

        run_op("disturb", 32'hCAFE_F00D, 32'h0000_1234, 1'b0, 1'b1);

        run_op("b2b_0", $urandom, W'($urandom_range(1, 1000)), 1'b1, 1'b0);
        run_op("b2b_1", $urandom, $urandom, 1'b1, 1'b1);
        run_op("b2b_2", $urandom, W'($urandom_range(1, 65535)), 1'b0, 1'b0);

        check_eq("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
